// File: rtl/uart_command_controller_pkg.sv
// Shared definitions for the UART command controller: command codes, error causes,
// frame geometry and the controller state encoding.
package uart_command_controller_pkg;

  localparam logic [7:0] CMD_FREQUENCY = 8'h01;
  localparam logic [7:0] CMD_GAIN      = 8'h02;
  localparam logic [7:0] CMD_ENABLE    = 8'h03;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_COMMAND  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int FRAME_PAYLOAD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    CHECK
  } state_t;

  // Error counter holds at all-ones rather than wrapping back to a misleading small value
  function automatic logic [15:0] saturatingIncrement(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/uart_command_controller_if.sv
// Received-byte stream from the UART receiver: a one-cycle available strobe with its byte.
interface uart_command_controller_if;

  logic       available;
  logic [7:0] data;

  modport master (
    output available,
    output data
  );

  modport slave (
    input available,
    input data
  );

endinterface

// File: rtl/uart_command_controller_frame_watchdog.sv
// Inter-byte watchdog: counts idle cycles while a frame is running and flags when the
// allowed gap has been reached. The count stops at the limit so it never wraps.
module frame_watchdog #(
  parameter int timeoutCycles = 76_800,
  parameter int timerBits     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [timerBits-1:0] LIMIT = timerBits'(timeoutCycles);

  logic [timerBits-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset || clear || !run) begin
      timer <= '0;
    end else if (!expired) begin
      timer <= timer + timerBits'(1);
    end
  end

  assign expired = (timer == LIMIT);

endmodule

// File: rtl/uart_command_controller.sv
// Frames the UART byte stream into SYNC/CMD/4xDATA/CHK commands and applies validated
// commands atomically to the FM transmitter configuration registers.
module uart_command_controller
  import uart_command_controller_pkg::*;
#(
  parameter int         clockRate     = 76_800_000,
  parameter int         timeoutCycles = 76_800,
  parameter int         timerBits     = 20,
  parameter logic [7:0] syncByte      = 8'hA5
) (
  input  logic                             clk,
  input  logic                             reset,
  uart_command_controller_if.slave         rx,
  output logic [31:0]                      frequencyWord,
  output logic [15:0]                      gain,
  output logic                             enable,
  output logic                             update,
  output logic                             busy,
  output logic [15:0]                      frameCount,
  output logic [15:0]                      errorCount,
  output logic [1:0]                       lastError
);

  if (clockRate < 1 || timeoutCycles < 2 || timerBits < 2 || timerBits > 30 ||
      timeoutCycles >= (1 << timerBits)) begin : gen_bad_parameters
    $error("uart_command_controller: timeoutCycles must be >= 2 and fit in timerBits");
  end

  localparam logic [1:0] LAST_INDEX = 2'(FRAME_PAYLOAD_BYTES - 1);

  state_t      state, stateNext;
  logic [7:0]  command, commandNext;
  logic [7:0]  checksum, checksumNext;
  logic [31:0] payload, payloadNext;
  logic [1:0]  byteIndex, byteIndexNext;

  logic [31:0] frequencyWordNext;
  logic [15:0] gainNext;
  logic        enableNext;
  logic        updateNext;
  logic [15:0] frameCountNext;
  logic [15:0] errorCountNext;
  logic [1:0]  lastErrorNext;

  logic expired;
  logic timedOut;

  frame_watchdog #(
    .timeoutCycles (timeoutCycles),
    .timerBits     (timerBits)
  ) watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx.available),
    .run     (state != IDLE),
    .expired (expired)
  );

  // A byte landing on the expiry cycle takes priority over the timeout
  assign timedOut = expired && (state != IDLE) && !rx.available;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      command       <= '0;
      checksum      <= '0;
      payload       <= '0;
      byteIndex     <= '0;
      frequencyWord <= '0;
      gain          <= '0;
      enable        <= 1'b0;
      update        <= 1'b0;
      frameCount    <= '0;
      errorCount    <= '0;
      lastError     <= ERR_NONE;
    end else begin
      state         <= stateNext;
      command       <= commandNext;
      checksum      <= checksumNext;
      payload       <= payloadNext;
      byteIndex     <= byteIndexNext;
      frequencyWord <= frequencyWordNext;
      gain          <= gainNext;
      enable        <= enableNext;
      update        <= updateNext;
      frameCount    <= frameCountNext;
      errorCount    <= errorCountNext;
      lastError     <= lastErrorNext;
    end
  end

  always_comb begin
    stateNext         = state;
    commandNext       = command;
    checksumNext      = checksum;
    payloadNext       = payload;
    byteIndexNext     = byteIndex;
    frequencyWordNext = frequencyWord;
    gainNext          = gain;
    enableNext        = enable;
    updateNext        = 1'b0;
    frameCountNext    = frameCount;
    errorCountNext    = errorCount;
    lastErrorNext     = lastError;

    case (state)
      IDLE: begin
        if (rx.available && rx.data == syncByte) begin
          stateNext = CMD;
        end
      end
      CMD: begin
        if (rx.available) begin
          commandNext   = rx.data;
          checksumNext  = rx.data;
          byteIndexNext = '0;
          stateNext     = DATA;
        end
      end
      DATA: begin
        // D0 arrives first, so shifting in from the top leaves it in the low byte
        if (rx.available) begin
          payloadNext   = {rx.data, payload[31:8]};
          checksumNext  = checksum ^ rx.data;
          byteIndexNext = byteIndex + 2'd1;
          if (byteIndex == LAST_INDEX) begin
            stateNext = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx.available) begin
          stateNext = IDLE;
          if (rx.data != checksum) begin
            errorCountNext = saturatingIncrement(errorCount);
            lastErrorNext  = ERR_CHECKSUM;
          end else begin
            case (command)
              CMD_FREQUENCY: begin
                frequencyWordNext = payload;
                updateNext        = 1'b1;
                frameCountNext    = frameCount + 16'd1;
              end
              CMD_GAIN: begin
                gainNext       = payload[15:0];
                updateNext     = 1'b1;
                frameCountNext = frameCount + 16'd1;
              end
              CMD_ENABLE: begin
                enableNext     = payload[0];
                updateNext     = 1'b1;
                frameCountNext = frameCount + 16'd1;
              end
              default: begin
                errorCountNext = saturatingIncrement(errorCount);
                lastErrorNext  = ERR_COMMAND;
              end
            endcase
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (timedOut) begin
      stateNext      = IDLE;
      errorCountNext = saturatingIncrement(errorCount);
      lastErrorNext  = ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_uart_command_controller.sv
// Randomised self-checking bench for uart_command_controller against a frame-level
// reference model built from byte queues and idle-gap counts.
module tb_uart_command_controller;

  localparam int         TIMEOUT = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic clk = 1'b0;
  logic reset;

  uart_command_controller_if rx();

  logic [31:0] frequencyWord;
  logic [15:0] gain;
  logic        enable;
  logic        update;
  logic        busy;
  logic [15:0] frameCount;
  logic [15:0] errorCount;
  logic [1:0]  lastError;

  uart_command_controller #(
    .clockRate     (76_800_000),
    .timeoutCycles (TIMEOUT),
    .timerBits     (8),
    .syncByte      (SYNC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .frequencyWord (frequencyWord),
    .gain          (gain),
    .enable        (enable),
    .update        (update),
    .busy          (busy),
    .frameCount    (frameCount),
    .errorCount    (errorCount),
    .lastError     (lastError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int updatesSeen = 0;

  // Reference model: bytes of the frame in progress and idle cycles since the last byte
  logic [7:0]  frameQ[$];
  int          idleCount = 0;
  logic [31:0] mFreq = '0;
  logic [15:0] mGain = '0;
  logic        mEnable = 1'b0;
  logic [15:0] mFrames = '0;
  logic [15:0] mErrors = '0;
  logic [1:0]  mLastError = '0;
  int          mUpdates = 0;

  function automatic void modelReset();
    frameQ.delete();
    idleCount  = 0;
    mFreq      = '0;
    mGain      = '0;
    mEnable    = 1'b0;
    mFrames    = '0;
    mErrors    = '0;
    mLastError = '0;
  endfunction

  function automatic void modelError(input logic [1:0] cause);
    if (mErrors != 16'hFFFF) mErrors = mErrors + 16'd1;
    mLastError = cause;
  endfunction

  function automatic void modelApplied();
    mFrames  = mFrames + 16'd1;
    mUpdates = mUpdates + 1;
  endfunction

  function automatic void modelEvaluate();
    logic [7:0]  chk;
    logic [31:0] p;
    chk = frameQ[1] ^ frameQ[2] ^ frameQ[3] ^ frameQ[4] ^ frameQ[5];
    p   = {frameQ[5], frameQ[4], frameQ[3], frameQ[2]};
    if (frameQ[6] != chk) modelError(2'd1);
    else if (frameQ[1] == 8'h01) begin mFreq = p; modelApplied(); end
    else if (frameQ[1] == 8'h02) begin mGain = p[15:0]; modelApplied(); end
    else if (frameQ[1] == 8'h03) begin mEnable = p[0]; modelApplied(); end
    else modelError(2'd2);
  endfunction

  function automatic void modelStep(input logic avail, input logic [7:0] b);
    if (avail) begin
      idleCount = 0;
      if (frameQ.size() == 0) begin
        if (b == SYNC) frameQ.push_back(b);
      end else begin
        frameQ.push_back(b);
        if (frameQ.size() == 7) begin
          modelEvaluate();
          frameQ.delete();
        end
      end
    end else if (frameQ.size() != 0) begin
      idleCount++;
      if (idleCount == TIMEOUT + 1) begin
        modelError(2'd3);
        frameQ.delete();
      end
    end
  endfunction

  task automatic tick(input logic avail, input logic [7:0] b);
    rx.available = avail;
    rx.data      = b;
    @(posedge clk);
    #1;
    if (reset) modelReset();
    else modelStep(avail, b);
    if (update === 1'b1) updatesSeen++;
    rx.available = 1'b0;
    rx.data      = 8'($urandom);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    repeat (gap) tick(1'b0, 8'h00);
    tick(1'b1, b);
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] p, input logic [7:0] corrupt,
                           input int longGapAt, input int longGap);
    logic [7:0] bytes[7];
    bytes[0] = SYNC;
    bytes[1] = cmd;
    bytes[2] = p[7:0];
    bytes[3] = p[15:8];
    bytes[4] = p[23:16];
    bytes[5] = p[31:24];
    bytes[6] = cmd ^ p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24] ^ corrupt;
    for (int i = 0; i < 7; i++) sendByte(bytes[i], (i == longGapAt) ? longGap : 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b0, 8'h00);
    tick(1'b1, SYNC);
    reset = 1'b0;
    tick(1'b0, 8'h00);
    checks++; if (frequencyWord !== 32'h0) begin failures++; $display("[TB] FAIL reset_frequencyWord got %h expected 0", frequencyWord); end
    checks++; if (gain !== 16'h0) begin failures++; $display("[TB] FAIL reset_gain got %h expected 0", gain); end
    checks++; if (enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable got %b expected 0", enable); end
    checks++; if (update !== 1'b0) begin failures++; $display("[TB] FAIL reset_update got %b expected 0", update); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b expected 0 (byte during reset must drop)", busy); end
    checks++; if (frameCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_frameCount got %0d expected 0", frameCount); end
    checks++; if (errorCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_errorCount got %0d expected 0", errorCount); end
    checks++; if (lastError !== 2'd0) begin failures++; $display("[TB] FAIL reset_lastError got %0d expected 0", lastError); end
  endtask

  task automatic test_frequency();
    int base;
    base = updatesSeen;
    sendFrame(8'h01, 32'h0010_0000, 8'h00, 0, 0);
    checks++; if (frequencyWord !== 32'h0010_0000) begin failures++; $display("[TB] FAIL freq_value got %h expected 00100000", frequencyWord); end
    checks++; if (update !== 1'b1) begin failures++; $display("[TB] FAIL freq_update got %b expected 1", update); end
    checks++; if (frameCount !== 16'd1) begin failures++; $display("[TB] FAIL freq_frameCount got %0d expected 1", frameCount); end
    checks++; if (errorCount !== 16'd0) begin failures++; $display("[TB] FAIL freq_errorCount got %0d expected 0", errorCount); end
    tick(1'b0, 8'h00);
    checks++; if (update !== 1'b0) begin failures++; $display("[TB] FAIL freq_update_pulse got %b expected 0", update); end
    checks++; if (updatesSeen - base !== 1) begin failures++; $display("[TB] FAIL freq_pulses got %0d expected 1", updatesSeen - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = updatesSeen;
    sendFrame(8'h02, 32'h0000_1234, 8'h00, 0, 0);
    checks++; if (gain !== 16'h1234) begin failures++; $display("[TB] FAIL b2b_gain got %h expected 1234", gain); end
    sendFrame(8'h03, 32'h0000_0001, 8'h00, 0, 0);
    checks++; if (enable !== 1'b1) begin failures++; $display("[TB] FAIL b2b_enable got %b expected 1", enable); end
    tick(1'b0, 8'h00);
    checks++; if (updatesSeen - base !== 2) begin failures++; $display("[TB] FAIL b2b_pulses got %0d expected 2", updatesSeen - base); end
    checks++; if (frameCount !== 16'd3) begin failures++; $display("[TB] FAIL b2b_frameCount got %0d expected 3", frameCount); end
  endtask

  task automatic test_errors();
    sendFrame(8'h01, 32'h0010_0000, 8'h03, 0, 0);
    checks++; if (update !== 1'b0) begin failures++; $display("[TB] FAIL badchk_update got %b expected 0", update); end
    checks++; if (frequencyWord !== 32'h0010_0000) begin failures++; $display("[TB] FAIL badchk_freq got %h expected 00100000", frequencyWord); end
    checks++; if (errorCount !== 16'd1 || lastError !== 2'd1) begin failures++; $display("[TB] FAIL badchk_error got %0d/%0d expected 1/1", errorCount, lastError); end
    sendFrame(8'h07, 32'h0000_0000, 8'h00, 0, 0);
    checks++; if (errorCount !== 16'd2 || lastError !== 2'd2) begin failures++; $display("[TB] FAIL unknown_error got %0d/%0d expected 2/2", errorCount, lastError); end
    sendFrame(8'h07, 32'h0000_0000, 8'h40, 0, 0);
    checks++; if (errorCount !== 16'd3 || lastError !== 2'd1) begin failures++; $display("[TB] FAIL unknown_badchk got %0d/%0d expected 3/1", errorCount, lastError); end
    checks++; if (frameCount !== mFrames) begin failures++; $display("[TB] FAIL errors_frameCount got %0d expected %0d", frameCount, mFrames); end
  endtask

  task automatic test_timeout();
    int waited;
    waited = 0;
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL timeout_busy_before got %b expected 1", busy); end
    while (busy === 1'b1 && waited < TIMEOUT + 4) begin
      tick(1'b0, 8'h00);
      waited++;
    end
    checks++; if (waited !== TIMEOUT + 1) begin failures++; $display("[TB] FAIL timeout_latency got %0d idle cycles expected %0d", waited, TIMEOUT + 1); end
    checks++; if (errorCount !== 16'd4 || lastError !== 2'd3) begin failures++; $display("[TB] FAIL timeout_error got %0d/%0d expected 4/3", errorCount, lastError); end
    sendFrame(8'h02, 32'h5555_BEEF, 8'h00, 0, 0);
    checks++; if (gain !== 16'hBEEF || frameCount !== mFrames) begin failures++; $display("[TB] FAIL timeout_recover got %h/%0d expected beef/%0d", gain, frameCount, mFrames); end
  endtask

  task automatic test_garbage_boundary();
    logic [15:0] errBefore;
    errBefore = mErrors;
    sendByte(8'h00, 0);
    sendByte(8'hFF, 1);
    sendByte(8'h5A, 0);
    checks++; if (busy !== 1'b0 || errorCount !== errBefore) begin failures++; $display("[TB] FAIL garbage got busy=%b err=%0d expected 0/%0d", busy, errorCount, errBefore); end
    sendFrame(8'h01, 32'hCAFE_0001, 8'h00, 3, TIMEOUT);
    checks++; if (frequencyWord !== 32'hCAFE_0001) begin failures++; $display("[TB] FAIL boundary_freq got %h expected cafe0001", frequencyWord); end
    checks++; if (errorCount !== errBefore || lastError !== 2'd3) begin failures++; $display("[TB] FAIL boundary_error got %0d/%0d expected %0d/3", errorCount, lastError, errBefore); end
    sendFrame(8'h02, 32'h0000_7777, 8'h00, 4, TIMEOUT + 1);
    tick(1'b0, 8'h00);
    checks++; if (gain === 16'h7777 || errorCount !== mErrors || lastError !== 2'd3) begin failures++; $display("[TB] FAIL overrun got gain=%h err=%0d/%0d expected err=%0d/3", gain, errorCount, lastError, mErrors); end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [31:0] p;
    logic [7:0]  corrupt;
    int          gapSel;
    int          longGap;
    for (int iter = 0; iter < 40; iter++) begin
      cmd = ($urandom_range(3) == 3) ? 8'($urandom_range(255)) : 8'($urandom_range(3, 1));
      p = $urandom;
      corrupt = ($urandom_range(4) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      gapSel = $urandom_range(9);
      longGap = (gapSel < 5) ? $urandom_range(2) : (gapSel < 7) ? TIMEOUT : (gapSel < 8) ? TIMEOUT - 1 : TIMEOUT + 1;
      if ($urandom_range(3) == 0) sendByte(8'($urandom_range(255)), $urandom_range(2));
      sendFrame(cmd, p, corrupt, $urandom_range(6, 1), longGap);
      repeat ($urandom_range(2)) tick(1'b0, 8'h00);
      checks++; if (frequencyWord !== mFreq) begin failures++; $display("[TB] FAIL rand%0d_freq got %h expected %h", iter, frequencyWord, mFreq); end
      checks++; if (gain !== mGain) begin failures++; $display("[TB] FAIL rand%0d_gain got %h expected %h", iter, gain, mGain); end
      checks++; if (enable !== mEnable) begin failures++; $display("[TB] FAIL rand%0d_enable got %b expected %b", iter, enable, mEnable); end
      checks++; if (frameCount !== mFrames) begin failures++; $display("[TB] FAIL rand%0d_frameCount got %0d expected %0d", iter, frameCount, mFrames); end
      checks++; if (errorCount !== mErrors) begin failures++; $display("[TB] FAIL rand%0d_errorCount got %0d expected %0d", iter, errorCount, mErrors); end
      checks++; if (lastError !== mLastError) begin failures++; $display("[TB] FAIL rand%0d_lastError got %0d expected %0d", iter, lastError, mLastError); end
      checks++; if (busy !== (frameQ.size() != 0)) begin failures++; $display("[TB] FAIL rand%0d_busy got %b expected %b", iter, busy, frameQ.size() != 0); end
      checks++; if (updatesSeen !== mUpdates) begin failures++; $display("[TB] FAIL rand%0d_updates got %0d expected %0d", iter, updatesSeen, mUpdates); end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midreset_busy_before got %b expected 1", busy); end
    reset = 1'b1;
    tick(1'b1, 8'h10);
    reset = 1'b0;
    checks++; if (frequencyWord !== 32'h0 || gain !== 16'h0 || enable !== 1'b0) begin failures++; $display("[TB] FAIL midreset_config got %h/%h/%b expected 0/0/0", frequencyWord, gain, enable); end
    checks++; if (frameCount !== 16'h0 || errorCount !== 16'h0 || lastError !== 2'd0) begin failures++; $display("[TB] FAIL midreset_counters got %0d/%0d/%0d expected 0/0/0", frameCount, errorCount, lastError); end
    checks++; if (busy !== 1'b0 || update !== 1'b0) begin failures++; $display("[TB] FAIL midreset_status got busy=%b update=%b expected 0/0", busy, update); end
    base = updatesSeen;
    sendByte(8'h00, 0);
    sendByte(8'h11, 0);
    repeat (TIMEOUT + 3) tick(1'b0, 8'h00);
    checks++; if (updatesSeen !== base) begin failures++; $display("[TB] FAIL midreset_trailing_update got %0d pulses expected 0", updatesSeen - base); end
    checks++; if (errorCount !== 16'h0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_trailing got err=%0d busy=%b expected 0/0", errorCount, busy); end
  endtask

  initial begin
    reset        = 1'b1;
    rx.available = 1'b0;
    rx.data      = 8'h00;
    test_reset();
    test_frequency();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_garbage_boundary();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog simulation did not complete in time");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
